// File: rtl/booth_r4_pkg.sv
// Shared definitions for the radix-4 Booth multiplier: FSM state encodings,
// Booth digit encoding and the 3-bit recode function.
package booth_r4_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    BUSY = 2'b01,
    DONE = 2'b11
  } state_t;

  typedef enum logic [2:0] {
    ZERO = 3'd0,
    POS1 = 3'd1,
    POS2 = 3'd2,
    NEG1 = 3'd3,
    NEG2 = 3'd4
  } digit_t;

  // Window is {B[i+1], B[i], B[i-1]}; the digit weights A by -2B[i+1] + B[i] + B[i-1].
  function automatic digit_t boothRecode(input logic [2:0] window);
    case (window)
      3'b001, 3'b010: return POS1;
      3'b011:         return POS2;
      3'b100:         return NEG2;
      3'b101, 3'b110: return NEG1;
      default:        return ZERO;
    endcase
  endfunction

endpackage

// File: rtl/booth_r4_mul_if.sv
// Handshake, operand and result bundle for booth_r4_mul.
// op_unsigned exists only when BOOTH_R4_UNSIGNED_EN is defined.
interface booth_r4_mul_if #(
  parameter int WIDTH = 64
);

  logic               op_start;
  logic               op_clear;
  logic [WIDTH-1:0]   multiplicand;
  logic [WIDTH-1:0]   multiplier;
`ifdef BOOTH_R4_UNSIGNED_EN
  logic               op_unsigned;
`endif
  logic [2*WIDTH-1:0] result;
  logic               op_done;
  logic               busy;

  modport master (
`ifdef BOOTH_R4_UNSIGNED_EN
    output op_unsigned,
`endif
    output op_start, op_clear, multiplicand, multiplier,
    input  result, op_done, busy
  );

  modport slave (
`ifdef BOOTH_R4_UNSIGNED_EN
    input  op_unsigned,
`endif
    input  op_start, op_clear, multiplicand, multiplier,
    output result, op_done, busy
  );

endinterface

// File: rtl/booth_r4_step.sv
// One radix-4 Booth iteration: adds the recoded digit (0, +-A, +-2A) to the
// accumulator upper half. This is the only adder in the multiplier.
module booth_r4_step
  import booth_r4_pkg::*;
#(
  parameter int E = 10
) (
  input  logic [E+1:0] accHi_i,
  input  logic [E-1:0] opA_i,
  input  logic [2:0]   bits_i,
  output logic [E+1:0] accHi_o
);

  logic [E+1:0] aExt;
  logic [E+1:0] magnitude;
  logic [E+1:0] addend;
  logic         negate;

  // Subtraction is folded into the same adder as ~A with a carry-in of one.
  always_comb begin
    aExt      = {{2{opA_i[E-1]}}, opA_i};
    magnitude = '0;
    negate    = 1'b0;
    case (boothRecode(bits_i))
      POS1: magnitude = aExt;
      POS2: magnitude = aExt << 1;
      NEG1: begin
        magnitude = aExt;
        negate    = 1'b1;
      end
      NEG2: begin
        magnitude = aExt << 1;
        negate    = 1'b1;
      end
      default: magnitude = '0;
    endcase
    addend  = negate ? ~magnitude : magnitude;
    accHi_o = accHi_i + addend + {{(E+1){1'b0}}, negate};
  end

endmodule

// File: rtl/booth_r4_mul.sv
// Iterative radix-4 Booth multiplier, two multiplier bits per cycle, 2*WIDTH product.
// Optional unsigned mode is enabled by defining BOOTH_R4_UNSIGNED_EN.
module booth_r4_mul
  import booth_r4_pkg::*;
#(
  parameter int WIDTH = 64
) (
  input  logic           clk,
  input  logic           reset_n,
  booth_r4_mul_if.slave  io
);

  localparam int E  = WIDTH + 2;
  localparam int N  = E / 2;
  localparam int CW = $clog2(N);
  localparam logic [CW-1:0] LAST_CNT = CW'(N - 1);

  state_t             state_q, state_d;
  logic [E-1:0]       opA_q, opA_d;
  logic [E+1:0]       accHi_q, accHi_d;
  logic [E-1:0]       accLo_q, accLo_d;
  logic               prevBit_q, prevBit_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [2*WIDTH-1:0] result_q, result_d;

  logic               extSign;
  logic [E+1:0]       stepSum;

`ifdef BOOTH_R4_UNSIGNED_EN
  assign extSign = ~io.op_unsigned;
`else
  assign extSign = 1'b1;
`endif

  booth_r4_step #(.E(E)) uStep (
    .accHi_i (accHi_q),
    .opA_i   (opA_q),
    .bits_i  ({accLo_q[1:0], prevBit_q}),
    .accHi_o (stepSum)
  );

  // accLo_q starts as the extended multiplier and fills with product bits as it shifts.
  always_comb begin
    state_d   = state_q;
    opA_d     = opA_q;
    accHi_d   = accHi_q;
    accLo_d   = accLo_q;
    prevBit_d = prevBit_q;
    cnt_d     = cnt_q;
    result_d  = result_q;
    if (io.op_clear) begin
      state_d  = IDLE;
      result_d = '0;
      cnt_d    = '0;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          if (io.op_start) begin
            state_d   = BUSY;
            opA_d     = {{2{extSign & io.multiplicand[WIDTH-1]}}, io.multiplicand};
            accLo_d   = {{2{extSign & io.multiplier[WIDTH-1]}}, io.multiplier};
            accHi_d   = '0;
            prevBit_d = 1'b0;
            cnt_d     = '0;
          end
        end
        BUSY: begin
          accHi_d   = {{2{stepSum[E+1]}}, stepSum[E+1:2]};
          accLo_d   = {stepSum[1:0], accLo_q[E-1:2]};
          prevBit_d = accLo_q[1];
          cnt_d     = cnt_q + CW'(1);
          if (cnt_q == LAST_CNT) begin
            state_d  = DONE;
            result_d = {accHi_d[WIDTH-3:0], accLo_d};
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      opA_q     <= '0;
      accHi_q   <= '0;
      accLo_q   <= '0;
      prevBit_q <= 1'b0;
      cnt_q     <= '0;
      result_q  <= '0;
    end else begin
      state_q   <= state_d;
      opA_q     <= opA_d;
      accHi_q   <= accHi_d;
      accLo_q   <= accLo_d;
      prevBit_q <= prevBit_d;
      cnt_q     <= cnt_d;
      result_q  <= result_d;
    end
  end

  assign io.result  = result_q;
  assign io.op_done = (state_q == DONE);
  assign io.busy    = (state_q == BUSY);

endmodule

// File: tb/tb_booth_r4_mul.sv
// Self-checking bench for booth_r4_mul: an 8-bit and a 64-bit instance checked
// against an arithmetic reference product; BOOTH_R4_UNSIGNED_EN adds unsigned cases.
module tb_booth_r4_mul;

  logic clk;
  logic reset_n;
  int checks = 0;
  int errors = 0;
  logic [127:0] prev8  = '0;
  logic [127:0] prev64 = '0;

  booth_r4_mul_if #(.WIDTH(8))  if8 ();
  booth_r4_mul_if #(.WIDTH(64)) ifW ();

  booth_r4_mul #(.WIDTH(8)) dut8 (
    .clk     (clk),
    .reset_n (reset_n),
    .io      (if8.slave)
  );

  booth_r4_mul #(.WIDTH(64)) dut64 (
    .clk     (clk),
    .reset_n (reset_n),
    .io      (ifW.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference: plain multiplication of the operands extended to 128 bits.
  function automatic logic [127:0] refProduct(input bit wide, input logic [63:0] a,
                                              input logic [63:0] b, input bit uns);
    logic signed [127:0] sa, sb, p;
    if (wide) begin
      sa = uns ? {64'b0, a} : {{64{a[63]}}, a};
      sb = uns ? {64'b0, b} : {{64{b[63]}}, b};
      p  = sa * sb;
      return p;
    end
    sa = uns ? {120'b0, a[7:0]} : {{120{a[7]}}, a[7:0]};
    sb = uns ? {120'b0, b[7:0]} : {{120{b[7]}}, b[7:0]};
    p  = sa * sb;
    return {112'b0, p[15:0]};
  endfunction

  function automatic logic [127:0] resultOf(input bit wide);
    return wide ? ifW.result : {112'b0, if8.result};
  endfunction

  function automatic logic [127:0] busyOf(input bit wide);
    return {127'b0, (wide ? ifW.busy : if8.busy)};
  endfunction

  function automatic logic [127:0] doneOf(input bit wide);
    return {127'b0, (wide ? ifW.op_done : if8.op_done)};
  endfunction

  task automatic driveOp(input bit wide, input logic [63:0] a, input logic [63:0] b,
                         input bit uns, input bit start, input bit clr);
    if (wide) begin
      ifW.multiplicand = a;
      ifW.multiplier   = b;
      ifW.op_start     = start;
      ifW.op_clear     = clr;
`ifdef BOOTH_R4_UNSIGNED_EN
      ifW.op_unsigned  = uns;
`endif
    end else begin
      if8.multiplicand = a[7:0];
      if8.multiplier   = b[7:0];
      if8.op_start     = start;
      if8.op_clear     = clr;
`ifdef BOOTH_R4_UNSIGNED_EN
      if8.op_unsigned  = uns;
`endif
    end
  endtask

  // Starts one multiply at the current negedge, pokes a stray op_start mid-BUSY,
  // and checks BUSY flag, held previous result, latency and final product.
  task automatic applyStimulus(input string tag, input bit wide, input logic [63:0] a,
                               input logic [63:0] b, input bit uns, input logic [127:0] exp);
    int cycles;
    int lat;
    logic [127:0] prev;
    cycles = 0;
    lat    = wide ? 33 : 5;
    prev   = wide ? prev64 : prev8;
    driveOp(wide, a, b, uns, 1'b1, 1'b0);
    @(negedge clk);
    driveOp(wide, a, b, uns, 1'b0, 1'b0);
    while (doneOf(wide) == 128'd0 && cycles < 100) begin
      checkOutput({tag, ".busy"}, busyOf(wide), 128'd1);
      checkOutput({tag, ".hold"}, resultOf(wide), prev);
      if (cycles == 2) driveOp(wide, ~a, ~b, ~uns, 1'b1, 1'b0);
      else             driveOp(wide, a, b, uns, 1'b0, 1'b0);
      @(negedge clk);
      cycles++;
    end
    driveOp(wide, a, b, uns, 1'b0, 1'b0);
    checkOutput({tag, ".lat"}, 128'(cycles), 128'(lat));
    checkOutput({tag, ".notBusy"}, busyOf(wide), 128'd0);
    checkOutput({tag, ".res"}, resultOf(wide), exp);
    if (wide) prev64 = exp;
    else      prev8  = exp;
  endtask

  initial begin
    logic [63:0] ra, rb;
    reset_n = 1'b1;
    driveOp(1'b0, 64'd0, 64'd0, 1'b0, 1'b0, 1'b0);
    driveOp(1'b1, 64'd0, 64'd0, 1'b0, 1'b0, 1'b0);
    #1 reset_n = 1'b0;
    repeat (2) @(negedge clk);
    checkOutput("rst.res8",  resultOf(1'b0), 128'd0);
    checkOutput("rst.busy8", busyOf(1'b0), 128'd0);
    checkOutput("rst.done8", doneOf(1'b0), 128'd0);
    checkOutput("rst.res64", resultOf(1'b1), 128'd0);
    reset_n = 1'b1;
    @(negedge clk);

    applyStimulus("s8.7xm3",    1'b0, 64'h07, 64'hFD, 1'b0, 128'hFFEB);
    applyStimulus("s8.zeroB2B", 1'b0, 64'h00, 64'h5A, 1'b0, 128'h0000);
    applyStimulus("s8.minSq",   1'b0, 64'h80, 64'h80, 1'b0, 128'h4000);
    applyStimulus("s8.minMax",  1'b0, 64'h80, 64'h7F, 1'b0, 128'hC080);
`ifdef BOOTH_R4_UNSIGNED_EN
    applyStimulus("u8.ff",      1'b0, 64'hFF, 64'hFF, 1'b1, 128'hFE01);
    applyStimulus("s8.ff",      1'b0, 64'hFF, 64'hFF, 1'b0, 128'h0001);
`endif

    // Clear together with start on the third BUSY cycle.
    driveOp(1'b0, 64'h33, 64'h44, 1'b0, 1'b1, 1'b0);
    @(negedge clk);
    driveOp(1'b0, 64'h33, 64'h44, 1'b0, 1'b0, 1'b0);
    repeat (2) @(negedge clk);
    driveOp(1'b0, 64'h33, 64'h44, 1'b0, 1'b1, 1'b1);
    @(negedge clk);
    driveOp(1'b0, 64'h33, 64'h44, 1'b0, 1'b0, 1'b0);
    checkOutput("clr.busy", busyOf(1'b0), 128'd0);
    checkOutput("clr.res",  resultOf(1'b0), 128'd0);
    repeat (8) begin
      checkOutput("clr.noDone", doneOf(1'b0), 128'd0);
      @(negedge clk);
    end
    prev8 = '0;
    applyStimulus("s8.afterClr", 1'b0, 64'h85, 64'h13, 1'b0, refProduct(1'b0, 64'h85, 64'h13, 1'b0));

    applyStimulus("s64.minSq",  1'b1, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b0,
                  128'h4000_0000_0000_0000_0000_0000_0000_0000);
    applyStimulus("s64.minMax", 1'b1, 64'h8000_0000_0000_0000, 64'h7FFF_FFFF_FFFF_FFFF, 1'b0,
                  refProduct(1'b1, 64'h8000_0000_0000_0000, 64'h7FFF_FFFF_FFFF_FFFF, 1'b0));

    // Asynchronous reset in the middle of BUSY.
    driveOp(1'b0, 64'h12, 64'h34, 1'b0, 1'b1, 1'b0);
    @(negedge clk);
    driveOp(1'b0, 64'h12, 64'h34, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    #1 reset_n = 1'b0;
    #1;
    checkOutput("arst.res8",  resultOf(1'b0), 128'd0);
    checkOutput("arst.busy8", busyOf(1'b0), 128'd0);
    checkOutput("arst.done8", doneOf(1'b0), 128'd0);
    checkOutput("arst.res64", resultOf(1'b1), 128'd0);
    @(negedge clk);
    reset_n = 1'b1;
    prev8  = '0;
    prev64 = '0;
    @(negedge clk);

    for (int i = 0; i < 100; i++) begin
      ra = 64'($urandom);
      rb = 64'($urandom);
      applyStimulus("r8", 1'b0, ra, rb, 1'b0, refProduct(1'b0, ra, rb, 1'b0));
`ifdef BOOTH_R4_UNSIGNED_EN
      applyStimulus("r8u", 1'b0, ra, rb, 1'b1, refProduct(1'b0, ra, rb, 1'b1));
`endif
    end

    for (int i = 0; i < 1000; i++) begin
      ra = {$urandom, $urandom};
      rb = {$urandom, $urandom};
      applyStimulus("r64", 1'b1, ra, rb, 1'b0, refProduct(1'b1, ra, rb, 1'b0));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/booth_r4_mul.md
# booth_r4_mul

Parametrised iterative radix-4 Booth multiplier with a start/done handshake. It retires two multiplier bits per cycle and produces a full-width 2·WIDTH product. It is the next-generation replacement for the fixed 64-bit Booth datapath in the arithmetic unit. It adds generic width, a clear/abort path, a busy flag, a registered result, and optional unsigned operation.

## Interface
- WIDTH, 64, operand width; even, ≥4
- clk  input  1  rising-edge clock
- reset_n  input  1  asynchronous, active-low reset
- op_start  input  1  start request; sampled only in IDLE or DONE
- op_clear  input  1  synchronous abort/clear; honoured in every state
- multiplicand  input  WIDTH  operand A, captured on accepted op_start
- multiplier  input  WIDTH  operand B, captured on accepted op_start
- op_unsigned  input  1  present only with BOOTH_R4_UNSIGNED_EN; 1 = operands unsigned, captured with operands
- result  output  2·WIDTH  registered product
- op_done  output  1  high while in DONE
- busy  output  1  high while in BUSY

## Operation
- States:
  - IDLE: reset state, encoding 2'b00.
  - BUSY: 2'b01.
  - DONE: 2'b11.
- Internal operand width is E = WIDTH+2. Operands are sign-extended, or zero-extended when unsigned. Iteration count N = E/2 = WIDTH/2+1, fixed regardless of mode.
- Accepted op_start (state IDLE or DONE, op_clear low):
  - capture extended operands;
  - clear the accumulator;
  - load the iteration counter with 0;
  - go to BUSY.
- Each BUSY cycle:
  - recode {B[i+1], B[i], B[i-1]} with implicit B[-1] = 0 into a digit in {0, ±1, ±2}·A;
  - add the digit to the accumulator upper half (2's complement; subtract as ~A+1);
  - arithmetic right shift by 2;
  - increment the counter.
- After the N-th iteration: result ← low 2·WIDTH bits of accumulator; go to DONE.
- DONE: op_done held high and result held until op_clear (→ IDLE) or a new accepted op_start (→ BUSY).
- op_start while BUSY is ignored; operands are not re-captured.
- op_clear in any state → IDLE next edge, result ← 0, counter ← 0. op_clear overrides a simultaneous op_start.
- Accumulator width is E+2 on the upper half, so that the ±2A digit with sign extension cannot overflow. The most-negative signed operand (e.g. −2^(WIDTH−1) squared) must produce the exact product.
- result changes only on DONE entry, op_clear, or reset. It holds the previous product throughout BUSY.

## Timing
- Reset (reset_n low, asynchronous):
  - state IDLE;
  - result 0, op_done 0, busy 0;
  - internal registers 0.
- Accepted op_start at edge k: busy = 1 from k through k+N−1. At edge k+N: op_done = 1, busy = 0, result valid.
- Latency is exactly N cycles, start edge to op_done (WIDTH=64 → 33; WIDTH=8 → 5).
- Back-to-back: op_start in the first DONE cycle restarts. op_done drops at the next edge and the old result is held until the new product lands.
- reset_n low mid-operation aborts immediately; no partial result is visible.
- op_done and busy are never high simultaneously.

## Configuration
- BOOTH_R4_UNSIGNED_EN defined:
  - op_unsigned port exists;
  - when op_unsigned = 1, operands are zero-extended to E and the result is the unsigned product.
- Not defined:
  - port is absent;
  - operands are always sign-extended (signed 2's-complement multiply).
- Latency is identical in both builds.

## Structure
- Package booth_r4_pkg:
  - state encodings IDLE/BUSY/DONE;
  - Booth digit encoding (ZERO, POS1, POS2, NEG1, NEG2);
  - a recode function from 3 bits to digit.
- Sub-module booth_r4_step (combinational, parameter E): accumulator-high, A, and 3 recode bits in; next accumulator-high out (add/sub ±A/±2A). It holds the only adder in the block.
- Top holds the FSM, counter, operand/accumulator registers, and result register.

## Test plan
- WIDTH=8, signed: A=7, B=−3 (8'hFD) → op_done 5 cycles after start; result 16'hFFEB.
- WIDTH=8, signed: A=B=8'h80 → result 16'h4000. A=8'h80, B=8'h7F → 16'hC080.
- WIDTH=8, BOOTH_R4_UNSIGNED_EN: op_unsigned=1, A=B=8'hFF → 16'hFE01. op_unsigned=0, same operands → 16'h0001.
- Prior result 16'hFFEB in DONE; new start with A=0, B=8'h5A → result stays 16'hFFEB during BUSY, then 16'h0000. op_start pulses during BUSY ignored.
- op_clear asserted on 3rd BUSY cycle together with op_start → IDLE next edge, result 0, op_done never asserts. reset_n low mid-BUSY → all outputs 0 asynchronously.
- WIDTH=64 random signed pairs (≥1000) against a reference model. Each completes in exactly 33 cycles.
